// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Command-side initiator for the four signed 16-bit ALU execution units
// (arith, logic, compare, shift). A single operation request is accepted over
// a valid/ready handshake. The 4-bit opcode is decoded into a one-hot unit
// enable and a 2-bit sub-function. The operands are presented to the units,
// the selected unit's registered result/flag is captured one cycle later, and
// the result is returned on a valid/ready response port.
//
// Sequence per command (rsp_ready held high):
//   edge N   : command accepted, enable for the selected unit rises
//   edge N+1 : enable drops, unit registers its result
//   edge N+2 : result/flag captured, rsp_valid rises
//   edge N+3 : response taken, cmd_ready rises again
//
// Ports
//   CLK, rst                       clock (rising edge), async reset (active low)
//   cmd_valid/cmd_ready            request handshake
//   cmd_op[3:2]                    unit: 00 arith, 01 logic, 10 cmp, 11 shift
//   cmd_op[1:0]                    sub-function forwarded on ALU_FUN
//   cmd_a, cmd_b                   operands
//   A, B, ALU_FUN                  operands/sub-function to the units
//   Arith/Logic/CMP/Shift_Enable   one-hot unit enables, high in ISSUE only
//   *_OUT, *_Flag                  registered unit results and flags
//   rsp_valid/rsp_ready            response handshake
//   rsp_data                       captured result, zero-extended for non-arith
//   rsp_unit                       unit that produced rsp_data
//   rsp_err                        selected unit flag was low at capture
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int IN_DATA_WIDTH   = 16,
    parameter int ARITH_OUT_WIDTH = 32,
    parameter int LOGIC_OUT_WIDTH = 16,
    parameter int CMP_OUT_WIDTH   = 16,
    parameter int SHIFT_OUT_WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       rst,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_op,
    input  logic [IN_DATA_WIDTH-1:0]   cmd_a,
    input  logic [IN_DATA_WIDTH-1:0]   cmd_b,

    output logic [IN_DATA_WIDTH-1:0]   A,
    output logic [IN_DATA_WIDTH-1:0]   B,
    output logic [1:0]                 ALU_FUN,
    output logic                       Arith_Enable,
    output logic                       Logic_Enable,
    output logic                       CMP_Enable,
    output logic                       Shift_Enable,

    input  logic [ARITH_OUT_WIDTH-1:0] Arith_OUT,
    input  logic [LOGIC_OUT_WIDTH-1:0] Logic_OUT,
    input  logic [CMP_OUT_WIDTH-1:0]   CMP_OUT,
    input  logic [SHIFT_OUT_WIDTH-1:0] SHIFT_OUT,
    input  logic                       Arith_Flag,
    input  logic                       Logic_Flag,
    input  logic                       CMP_Flag,
    input  logic                       SHIFT_Flag,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ARITH_OUT_WIDTH-1:0] rsp_data,
    output logic [1:0]                 rsp_unit,
    output logic                       rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] UNIT_ARITH = 2'd0;
    localparam logic [1:0] UNIT_LOGIC = 2'd1;
    localparam logic [1:0] UNIT_CMP   = 2'd2;
    localparam logic [1:0] UNIT_SHIFT = 2'd3;

    state_t                     r_state;
    logic [IN_DATA_WIDTH-1:0]   r_a;
    logic [IN_DATA_WIDTH-1:0]   r_b;
    logic [1:0]                 r_fun;
    logic [1:0]                 r_unit;
    logic [3:0]                 r_en;        // bit index = unit code
    logic                       r_rsp_valid;
    logic [ARITH_OUT_WIDTH-1:0] r_rsp_data;
    logic [1:0]                 r_rsp_unit;
    logic                       r_rsp_err;

    logic [ARITH_OUT_WIDTH-1:0] w_sel_data;
    logic                       w_sel_flag;

    // Result/flag of the unit named by the latched command. Narrow unit
    // results are zero-extended into the response width.
    // NOTE: every output of a combinational block gets a default assignment
    // first, so no path through the case leaves it unassigned (no latch).
    always_comb begin
        w_sel_data = '0;
        w_sel_flag = 1'b0;
        case (r_unit)
            UNIT_ARITH: begin
                w_sel_data = Arith_OUT;
                w_sel_flag = Arith_Flag;
            end
            UNIT_LOGIC: begin
                w_sel_data = ARITH_OUT_WIDTH'(Logic_OUT);
                w_sel_flag = Logic_Flag;
            end
            UNIT_CMP: begin
                w_sel_data = ARITH_OUT_WIDTH'(CMP_OUT);
                w_sel_flag = CMP_Flag;
            end
            UNIT_SHIFT: begin
                w_sel_data = ARITH_OUT_WIDTH'(SHIFT_OUT);
                w_sel_flag = SHIFT_Flag;
            end
            default: begin
                w_sel_data = '0;
                w_sel_flag = 1'b0;
            end
        endcase
    end

    // NOTE: state and all registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_fun       <= '0;
            r_unit      <= '0;
            r_en        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_unit  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            // Enables are a single-cycle pulse: only the accept edge sets one.
            r_en <= '0;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_a     <= cmd_a;
                        r_b     <= cmd_b;
                        r_fun   <= cmd_op[1:0];
                        r_unit  <= cmd_op[3:2];
                        r_en    <= 4'b0001 << cmd_op[3:2];
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_state <= S_WAIT;
                end

                // The unit registered its result at the end of ISSUE, so it
                // is visible on *_OUT/*_Flag throughout WAIT.
                S_WAIT: begin
                    r_rsp_data  <= w_sel_data;
                    r_rsp_unit  <= r_unit;
                    r_rsp_err   <= ~w_sel_flag;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // cmd_ready is a pure decode of the state register; commands presented in
    // any other state are simply not sampled.
    assign cmd_ready    = (r_state == S_IDLE);

    assign A            = r_a;
    assign B            = r_b;
    assign ALU_FUN      = r_fun;
    assign Arith_Enable = r_en[UNIT_ARITH];
    assign Logic_Enable = r_en[UNIT_LOGIC];
    assign CMP_Enable   = r_en[UNIT_CMP];
    assign Shift_Enable = r_en[UNIT_SHIFT];

    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_unit     = r_rsp_unit;
    assign rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Bench for alu_op_sequencer. The four execution units are emulated here:
// each registers its result and raises its flag on the edge after its enable,
// and drives random data with the flag low on every other cycle, so a capture
// taken at the wrong time is visible. Expected responses come from a
// reference that computes the unit function straight from (op, a, b).
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [15:0] A;
    logic [15:0] B;
    logic [1:0]  ALU_FUN;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [31:0] Arith_OUT = '0;
    logic [15:0] Logic_OUT = '0;
    logic [15:0] CMP_OUT = '0;
    logic [15:0] SHIFT_OUT = '0;
    logic        Arith_Flag = 1'b0;
    logic        Logic_Flag = 1'b0;
    logic        CMP_Flag = 1'b0;
    logic        SHIFT_Flag = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_unit;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;
    bit force_shift_flag_low = 1'b0;

    // Observations of the most recent issue_cmd call.
    int          obs_lat;
    logic [3:0]  obs_en;
    int          obs_en_cycles;
    int          obs_overlap;
    logic [33:0] obs_issue_ops;   // {A, B, ALU_FUN} during ISSUE
    logic [33:0] obs_wait_ops;    // {A, B, ALU_FUN} during WAIT
    bit          obs_ready_seen;

    alu_op_sequencer dut (
        .CLK          (CLK),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .A            (A),
        .B            (B),
        .ALU_FUN      (ALU_FUN),
        .Arith_Enable (Arith_Enable),
        .Logic_Enable (Logic_Enable),
        .CMP_Enable   (CMP_Enable),
        .Shift_Enable (Shift_Enable),
        .Arith_OUT    (Arith_OUT),
        .Logic_OUT    (Logic_OUT),
        .CMP_OUT      (CMP_OUT),
        .SHIFT_OUT    (SHIFT_OUT),
        .Arith_Flag   (Arith_Flag),
        .Logic_Flag   (Logic_Flag),
        .CMP_Flag     (CMP_Flag),
        .SHIFT_Flag   (SHIFT_Flag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_unit     (rsp_unit),
        .rsp_err      (rsp_err)
    );

    always #5 CLK = ~CLK;

    // ---------------- unit functions (signed 16-bit operands) ----------------
    function automatic logic [31:0] arith_fn(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            2'd0:    return 32'(sa + sb);
            2'd1:    return 32'(sa - sb);
            2'd2:    return 32'(sa * sb);
            default: return (sb == 0) ? 32'd0 : 32'(sa / sb);
        endcase
    endfunction

    function automatic logic [15:0] logic_fn(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic logic [15:0] cmp_fn(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            2'd0:    return (a == b) ? 16'd1 : 16'd0;
            2'd1:    return ($signed(a) > $signed(b)) ? 16'd2 : 16'd0;
            2'd2:    return ($signed(a) < $signed(b)) ? 16'd3 : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [15:0] shift_fn(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            2'd0:    return a >> 1;
            2'd1:    return a << 1;
            2'd2:    return b >> 1;
            default: return b << 1;
        endcase
    endfunction

    // Expected response word: arith as-is, the other units zero-extended.
    function automatic logic [31:0] ref_rsp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op[3:2])
            2'd0:    return arith_fn(op[1:0], a, b);
            2'd1:    return {16'h0000, logic_fn(op[1:0], a, b)};
            2'd2:    return {16'h0000, cmp_fn(op[1:0], a, b)};
            default: return {16'h0000, shift_fn(op[1:0], a, b)};
        endcase
    endfunction

    // ---------------- unit emulation ----------------
    always @(posedge CLK) begin
        Arith_OUT  <= Arith_Enable ? arith_fn(ALU_FUN, A, B) : 32'($urandom);
        Logic_OUT  <= Logic_Enable ? logic_fn(ALU_FUN, A, B) : 16'($urandom);
        CMP_OUT    <= CMP_Enable   ? cmp_fn(ALU_FUN, A, B)   : 16'($urandom);
        SHIFT_OUT  <= Shift_Enable ? shift_fn(ALU_FUN, A, B) : 16'($urandom);
        Arith_Flag <= Arith_Enable;
        Logic_Flag <= Logic_Enable;
        CMP_Flag   <= CMP_Enable;
        SHIFT_Flag <= Shift_Enable & ~force_shift_flag_low;
    end

    // ---------------- stimulus helpers (no checking) ----------------
    // Waits for cmd_ready, presents one command for a single cycle, then
    // scrambles the command inputs and watches until rsp_valid. Returns at
    // the falling edge where rsp_valid was first seen (obs_lat = -1 if never).
    task automatic issue_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int n;
        logic [3:0] w_en;
        obs_lat        = -1;
        obs_en         = '0;
        obs_en_cycles  = 0;
        obs_overlap    = 0;
        obs_issue_ops  = '0;
        obs_wait_ops   = '0;
        obs_ready_seen = 1'b0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_op    = 4'($urandom);
        cmd_a     = 16'($urandom);
        cmd_b     = 16'($urandom);
        for (int k = 0; k < 12; k++) begin
            w_en = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
            if (k == 0) begin
                obs_en        = w_en;
                obs_issue_ops = {A, B, ALU_FUN};
            end
            if (k == 1) obs_wait_ops = {A, B, ALU_FUN};
            if (w_en != 4'b0000) obs_en_cycles++;
            if ($countones(w_en) > 1) obs_overlap++;
            if (cmd_ready) obs_ready_seen = 1'b1;
            if (rsp_valid) begin
                obs_lat = k;
                break;
            end
            @(negedge CLK);
        end
    endtask

    // Runs one command with rsp_ready high and checks everything observable.
    task automatic run_and_check(input string name, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] exp_data;
        logic [3:0]  exp_en;
        exp_data = ref_rsp(op, a, b);
        exp_en   = 4'b0001 << op[3:2];
        rsp_ready = 1'b1;
        issue_cmd(op, a, b);
        checks++;
        if (obs_lat !== 2) begin
            failures++;
            $display("FAIL %s latency: got %0d negedges after accept, expected 2", name, obs_lat);
        end
        checks++;
        if (obs_en !== exp_en || obs_en_cycles !== 1 || obs_overlap !== 0) begin
            failures++;
            $display("FAIL %s enables: got %b (active %0d cycles, overlap %0d), expected %b for 1 cycle",
                     name, obs_en, obs_en_cycles, obs_overlap, exp_en);
        end
        checks++;
        if (obs_issue_ops !== {a, b, op[1:0]} || obs_wait_ops !== {a, b, op[1:0]}) begin
            failures++;
            $display("FAIL %s operands: issue %h wait %h, expected %h",
                     name, obs_issue_ops, obs_wait_ops, {a, b, op[1:0]});
        end
        checks++;
        if (rsp_data !== exp_data || rsp_unit !== op[3:2] || rsp_err !== 1'b0 || obs_ready_seen) begin
            failures++;
            $display("FAIL %s response: data=%h unit=%0d err=%b ready_seen=%b, expected data=%h unit=%0d err=0 ready_seen=0",
                     name, rsp_data, rsp_unit, rsp_err, obs_ready_seen, exp_data, op[3:2]);
        end
        @(negedge CLK);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s release: rsp_valid=%b cmd_ready=%b, expected 0 and 1", name, rsp_valid, cmd_ready);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, rsp_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_hold: enables/rsp_valid=%b, expected 00000",
                     {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, rsp_valid});
        end
        rst = 1'b1;
        @(negedge CLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready: got %b, expected 1", cmd_ready);
        end
        checks++;
        if ({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable} !== 4'b0) begin
            failures++;
            $display("FAIL reset_enables: got %b, expected 0000",
                     {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable});
        end
        checks++;
        if ({A, B, ALU_FUN} !== 34'b0) begin
            failures++;
            $display("FAIL reset_operands: got %h, expected 0", {A, B, ALU_FUN});
        end
        checks++;
        if ({rsp_valid, rsp_data, rsp_unit, rsp_err} !== 36'b0) begin
            failures++;
            $display("FAIL reset_response: valid=%b data=%h unit=%0d err=%b, expected all 0",
                     rsp_valid, rsp_data, rsp_unit, rsp_err);
        end
    endtask

    task automatic test_shift();
        run_and_check("shift_a_lsl", 4'b1101, 16'h4001, 16'($urandom));
        checks++;
        if (rsp_data !== 32'h0000_8002) begin
            failures++;
            $display("FAIL shift_value: got %h, expected 00008002", rsp_data);
        end
    endtask

    task automatic test_arith();
        run_and_check("arith_add", 4'b0000, 16'hFFFF, 16'h0002);
        checks++;
        if (rsp_data !== 32'h0000_0001) begin
            failures++;
            $display("FAIL arith_value: got %h, expected 00000001", rsp_data);
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [15:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = (i % 8 == 7) ? 16'h0000 : 16'($urandom);
            run_and_check("random", op, a, b);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  op;
        logic [15:0] a, b, a2, b2;
        logic [31:0] exp_data;
        int          bad;
        op = 4'($urandom_range(0, 15));
        a  = 16'($urandom);
        b  = 16'($urandom);
        exp_data  = ref_rsp(op, a, b);
        rsp_ready = 1'b0;
        issue_cmd(op, a, b);
        checks++;
        if (obs_lat !== 2 || rsp_data !== exp_data || rsp_unit !== op[3:2]) begin
            failures++;
            $display("FAIL bp_first_rsp: lat=%0d data=%h unit=%0d, expected lat=2 data=%h unit=%0d",
                     obs_lat, rsp_data, rsp_unit, exp_data, op[3:2]);
        end
        cmd_valid = 1'b1;
        cmd_op    = 4'b0101;
        cmd_a     = 16'($urandom);
        cmd_b     = 16'($urandom);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== exp_data ||
                rsp_unit !== op[3:2] || {A, B, ALU_FUN} !== {a, b, op[1:0]})
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d of 5 stalled cycles changed state (data=%h cmd_ready=%b), expected data=%h cmd_ready=0",
                     bad, rsp_data, cmd_ready, exp_data);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b, expected 0 and 1", rsp_valid, cmd_ready);
        end
        a2 = 16'($urandom);
        b2 = 16'($urandom);
        run_and_check("bp_next_logic", 4'b0101, a2, b2);
    endtask

    task automatic test_flag_err();
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        force_shift_flag_low = 1'b1;
        rsp_ready = 1'b1;
        issue_cmd(4'b1100, a, b);
        checks++;
        if (obs_lat !== 2 || rsp_err !== 1'b1 || rsp_unit !== 2'd3 || rsp_data !== {16'h0000, a >> 1}) begin
            failures++;
            $display("FAIL flag_err: lat=%0d err=%b unit=%0d data=%h, expected lat=2 err=1 unit=3 data=%h",
                     obs_lat, rsp_err, rsp_unit, rsp_data, {16'h0000, a >> 1});
        end
        @(negedge CLK);
        force_shift_flag_low = 1'b0;
        run_and_check("flag_ok_after", 4'b1100, a, b);
    endtask

    task automatic test_reset_mid_op();
        int seen;
        cmd_valid = 1'b1;
        cmd_op    = 4'b1001;
        cmd_a     = 16'h7FFF;
        cmd_b     = 16'h8000;
        @(negedge CLK);          // accepted; now in ISSUE
        cmd_valid = 1'b0;
        @(negedge CLK);          // now in WAIT
        rst = 1'b0;
        #1;
        checks++;
        if ({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, rsp_valid} !== 5'b0 ||
            {A, B, ALU_FUN} !== 34'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midop_reset: enables/valid=%b ops=%h cmd_ready=%b, expected 0/0/1",
                     {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, rsp_valid}, {A, B, ALU_FUN}, cmd_ready);
        end
        repeat (2) @(negedge CLK);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midop_dropped: rsp_valid high %0d cycles after reset, expected 0", seen);
        end
        run_and_check("midop_next", 4'b1001, 16'h7FFF, 16'h8000);
    endtask

    initial begin
        test_reset();
        test_shift();
        test_arith();
        test_random();
        test_backpressure();
        test_flag_err();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
